alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, handshaked successor to the 8-bit combinational ALU. Takes WIDTH-bit operands and a 4-bit opcode over a valid/ready input channel, computes single-cycle ops in one registered cycle, and runs multiply and divide iteratively (one bit per cycle) instead of with wide combinational arrays. Returns a registered result plus carry, zero and divide-by-zero flags over a valid/ready output channel. Sits between the register file / decode stage and writeback in the CPU datapath.

## Interface
- WIDTH, 8, operand/result width; legal range 4..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; transfer on in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result; transfer on out_valid && out_ready.
- result  out  WIDTH  registered result.
- carry  out  1  carry/borrow/overflow/shift-out flag.
- zero  out  1  result == 0.
- dbz  out  1  divide by zero occurred.
- busy  out  1  state != IDLE.

## Operation
- Opcode map:
  - 0000 ADD; 0001 SUB; 0010 MUL; 0011 DIV (unsigned quotient).
  - 0100 SHL1; 0101 SHR1; 0110 ROL1; 0111 ROR1.
  - 1000 AND; 1001 OR; 1010 XOR; 1011 NOR; 1100 NAND; 1101 XNOR.
  - 1110/1111 behave as ADD.
- Width rules: all results truncated to WIDTH bits.
- Carry flag by op:
  - ADD: carry out of the MSB.
  - SUB: borrow (a < b).
  - MUL: 1 if the upper WIDTH bits of the full 2·WIDTH product are nonzero.
  - SHL1: a[WIDTH-1]. SHR1: a[0].
  - All other ops: 0.
- dbz is 1 only for DIV with b == 0. In that case result = all-ones and carry = 0.
- States and transitions:
  - IDLE: accept takes single-cycle ops and DIV-by-zero to DONE; MUL to MUL; DIV (b != 0) to DIV.
  - MUL: shift-add, WIDTH iterations, then DONE.
  - DIV: restoring division, WIDTH iterations, then DONE.
  - DONE: out_valid = 1; outputs held stable until out_ready.
- Leaving DONE on out_ready:
  - If in_valid is also high, the new op is accepted in the same cycle (back-to-back).
  - Otherwise go to IDLE.
- in_ready = !rst && (state == IDLE || (state == DONE && out_ready)).
- a, b and op are sampled only on accept; later changes on the inputs are ignored.

## Timing
- Reset values: state IDLE; out_valid 0; result 0; carry 0; zero 0; dbz 0; busy 0; iteration counter 0. in_ready is 0 while rst is high.
- Reset mid-operation aborts the op. No out_valid is produced for it. in_ready = 1 in the first cycle after rst deasserts.
- Latency from the accept edge to out_valid high:
  - Single-cycle ops and DIV-by-zero: 1 cycle.
  - MUL and DIV: WIDTH+1 cycles.
- Iteration counter loads WIDTH on accept and decrements once per cycle in MUL/DIV. The transition to DONE happens on the edge where the counter is 1.
- Minimum issue interval: 1 cycle for single-cycle ops under back-to-back; WIDTH+1 for MUL/DIV.
- result, carry, zero and dbz change only on the edge that enters DONE. They never change while out_valid && !out_ready.

## Configuration
- Macro: ALU_ITER_MULDIV_EN.
- Defined: MUL/DIV behave as described above; the iterative sub-module is instantiated.
- Undefined:
  - Opcodes 0010/0011 complete in 1 cycle with result 0, carry 0, zero 1, dbz 0.
  - No MUL/DIV states, counter or sub-module are synthesised.

## Structure
- Package alu_pkg holds:
  - Opcode localparams (OP_ADD..OP_XNOR).
  - State enum (IDLE, MUL, DIV, DONE).
  - Flag bit-index constants.
- Sub-module alu_muldiv_iter:
  - Parametrised WIDTH; start/mode/done interface.
  - Holds the shift-add multiplier and restoring divider datapaths, plus the iteration counter.
- Top level holds: the FSM, the single-cycle combinational ops, and the output registers.

## Test plan
- WIDTH=8, ADD 200+100 -> result 0x2C, carry 1, zero 0; out_valid exactly 1 cycle after accept.
- WIDTH=8, MUL 20*13 -> result 0x04, carry 1; out_valid 9 cycles after accept. MUL 12*10 -> 0x78, carry 0.
- WIDTH=8, DIV 100/7 -> result 14, dbz 0, latency 9. DIV 5/0 -> result 0xFF, dbz 1, latency 1.
- Backpressure: hold out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0. Then assert out_ready with in_valid (XOR 0xF0^0xFF) -> accepted that cycle; result 0x0F one cycle later.
- Reset asserted on the 4th cycle of a DIV -> out_valid never rises for that op; all outputs at reset values; in_ready 1 the cycle after rst drops.
- WIDTH=16:
  - SUB 0x0001-0x0002 -> 0xFFFF, carry 1.
  - ROL1 0x8001 -> 0x0003.
  - SUB 0x1234-0x1234 -> zero 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for alu_iter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL1 = 4'b0100;
    localparam logic [3:0] OP_SHR1 = 4'b0101;
    localparam logic [3:0] OP_ROL1 = 4'b0110;
    localparam logic [3:0] OP_ROR1 = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_DBZ   = 2;
    localparam int unsigned FLAG_W     = 3;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider with its own
// iteration counter; o_result/o_carry show the value after the current step.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Multiply: {hi,lo} is the product register, multiplier consumed from lo[0].
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_mode) begin
            if (!w_diff[WIDTH]) begin
                w_hi_nxt = w_diff[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last   = (r_cnt == CW'(1));
    assign o_result = w_lo_nxt;
    assign o_carry  = !r_mode && (|w_hi_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (i_start) begin
            r_cnt  <= CW'(WIDTH);
            r_mode <= i_mode;
            r_hi   <= '0;
            r_lo   <= i_a;
            r_b    <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle ops plus optional iterative MUL/DIV.
// Iterative MUL/DIV is built only when ALU_ITER_MULDIV_EN is defined.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             dbz,
    output logic             busy
);

    state_t r_state;
    state_t w_next_state;
    state_t w_issue_state;

    logic [WIDTH-1:0]  r_result;
    logic [FLAG_W-1:0] r_flags;

    logic             w_accept;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_single_res;
    logic             w_single_carry;
    logic             w_single_dbz;
    logic             w_load_single;
    logic             w_load_iter;
    logic             w_iter_last;
    logic [WIDTH-1:0] w_iter_res;
    logic             w_iter_carry;

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_add          = {1'b0, a} + {1'b0, b};
        w_sub          = {1'b0, a} - {1'b0, b};
        w_single_res   = w_add[WIDTH-1:0];
        w_single_carry = w_add[WIDTH];
        w_single_dbz   = 1'b0;
        case (op)
            OP_SUB:  begin w_single_res = w_sub[WIDTH-1:0]; w_single_carry = w_sub[WIDTH]; end
            OP_MUL:  begin w_single_res = '0; w_single_carry = 1'b0; end
`ifdef ALU_ITER_MULDIV_EN
            OP_DIV:  begin w_single_res = '1; w_single_carry = 1'b0; w_single_dbz = (b == '0); end
`else
            OP_DIV:  begin w_single_res = '0; w_single_carry = 1'b0; end
`endif
            OP_SHL1: begin w_single_res = {a[WIDTH-2:0], 1'b0}; w_single_carry = a[WIDTH-1]; end
            OP_SHR1: begin w_single_res = {1'b0, a[WIDTH-1:1]}; w_single_carry = a[0]; end
            OP_ROL1: begin w_single_res = {a[WIDTH-2:0], a[WIDTH-1]}; w_single_carry = 1'b0; end
            OP_ROR1: begin w_single_res = {a[0], a[WIDTH-1:1]}; w_single_carry = 1'b0; end
            OP_AND:  begin w_single_res = a & b; w_single_carry = 1'b0; end
            OP_OR:   begin w_single_res = a | b; w_single_carry = 1'b0; end
            OP_XOR:  begin w_single_res = a ^ b; w_single_carry = 1'b0; end
            OP_NOR:  begin w_single_res = ~(a | b); w_single_carry = 1'b0; end
            OP_NAND: begin w_single_res = ~(a & b); w_single_carry = 1'b0; end
            OP_XNOR: begin w_single_res = ~(a ^ b); w_single_carry = 1'b0; end
            default: ;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    always_comb begin
        w_issue_state = DONE;
        if (op == OP_MUL)
            w_issue_state = MUL;
        else if (op == OP_DIV && b != '0)
            w_issue_state = DIV;
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && (w_issue_state != DONE)),
        .i_mode   (w_issue_state == DIV),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_iter_last),
        .o_result (w_iter_res),
        .o_carry  (w_iter_carry)
    );
`else
    assign w_issue_state = DONE;
    assign w_iter_last   = 1'b0;
    assign w_iter_res    = '0;
    assign w_iter_carry  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // DONE with out_ready doubles as an issue slot so single-cycle ops stream back-to-back.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next_state = w_issue_state;
            MUL, DIV: if (w_iter_last) w_next_state = DONE;
            DONE:     if (out_ready) w_next_state = w_accept ? w_issue_state : IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    assign w_load_single = w_accept && (w_issue_state == DONE);
    assign w_load_iter   = ((r_state == MUL) || (r_state == DIV)) && w_iter_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_load_single) begin
            r_result             <= w_single_res;
            r_flags[FLAG_CARRY]  <= w_single_carry;
            r_flags[FLAG_ZERO]   <= (w_single_res == '0);
            r_flags[FLAG_DBZ]    <= w_single_dbz;
        end else if (w_load_iter) begin
            r_result             <= w_iter_res;
            r_flags[FLAG_CARRY]  <= w_iter_carry;
            r_flags[FLAG_ZERO]   <= (w_iter_res == '0);
            r_flags[FLAG_DBZ]    <= 1'b0;
        end
    end

    assign result = r_result;
    assign carry  = r_flags[FLAG_CARRY];
    assign zero   = r_flags[FLAG_ZERO];
    assign dbz    = r_flags[FLAG_DBZ];

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter at WIDTH=8 and WIDTH=16; expectations follow
// ALU_ITER_MULDIV_EN when it is defined for the build.
module tb_alu_iter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        iv8, ir8, ov8, or8, c8, z8, d8, busy8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;
    logic        iv16, ir16, ov16, or16, c16, z16, d16, busy16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  op16;

    alu_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8), .carry(c8), .zero(z8), .dbz(d8), .busy(busy8)
    );

    alu_iter #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .op(op16),
        .out_valid(ov16), .out_ready(or16), .result(res16), .carry(c16), .zero(z16), .dbz(d16), .busy(busy16)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        d;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] res, input logic c, z, d, input int lat);
        exp_t e;
        e.tag = tag; e.res = res; e.c = c; e.z = z; e.d = d; e.lat = lat;
        return e;
    endfunction

    // Arithmetic reference model, independent of the RTL's bit-level datapaths.
    function automatic exp_t model(input string tag, input int unsigned w, input logic [3:0] op,
                                   input longint unsigned a, input longint unsigned b);
        longint unsigned m = (64'd1 << w) - 1;
        longint unsigned r = 0;
        longint unsigned p;
        logic c = 1'b0;
        logic d = 1'b0;
        int lat = 1;
        case (op)
            OP_SUB:  begin r = (a - b) & m; c = (a < b); end
`ifdef ALU_ITER_MULDIV_EN
            OP_MUL:  begin p = a * b; r = p & m; c = ((p >> w) != 0); lat = int'(w) + 1; end
            OP_DIV:  begin
                if (b == 0) begin r = m; d = 1'b1; end
                else begin r = a / b; lat = int'(w) + 1; end
            end
`else
            OP_MUL, OP_DIV: r = 0;
`endif
            OP_SHL1: begin r = (a * 2) & m; c = ((a >> (w - 1)) & 1) != 0; end
            OP_SHR1: begin r = a / 2; c = (a % 2) != 0; end
            OP_ROL1: r = ((a * 2) & m) + (a >> (w - 1));
            OP_ROR1: r = (a / 2) + ((a % 2) << (w - 1));
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b) & m;
            OP_NAND: r = ~(a & b) & m;
            OP_XNOR: r = ~(a ^ b) & m;
            default: begin p = a + b; r = p & m; c = (p > m); end
        endcase
        return mk(tag, 32'(r), c, (r == 0), d, lat);
    endfunction

    function automatic logic ovf(input bit w16);
        return w16 ? ov16 : ov8;
    endfunction

    function automatic logic irf(input bit w16);
        return w16 ? ir16 : ir8;
    endfunction

    task automatic scramble();
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
    endtask

    task automatic issue(input bit w16, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int g = 0;
        @(negedge clk);
        while (!irf(w16) && g < 50) begin @(negedge clk); g++; end
        chk("issue_ready", 32'(irf(w16)), 32'd1);
        if (w16) begin iv16 = 1'b1; a16 = a; b16 = b; op16 = op; end
        else begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; end
        @(posedge clk); #1;
        iv8 = 1'b0; iv16 = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(input bit w16, output int lat);
        lat = 1;
        while (!ovf(w16) && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic collect(input bit w16, input int lat, input bit rel);
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".lat"},   32'(lat), 32'(e.lat));
            chk({e.tag, ".res"},   w16 ? 32'(res16) : 32'(res8), e.res);
            chk({e.tag, ".carry"}, 32'(w16 ? c16 : c8), 32'(e.c));
            chk({e.tag, ".zero"},  32'(w16 ? z16 : z8), 32'(e.z));
            chk({e.tag, ".dbz"},   32'(w16 ? d16 : d8), 32'(e.d));
        end
        if (rel) begin
            or8 = 1'b1; or16 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0; or16 = 1'b0;
        end
    endtask

    task automatic run(input bit w16, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int lat;
        issue(w16, op, a, b);
        wait_valid(w16, lat);
        collect(w16, lat, 1'b1);
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
        a8 = '0; b8 = '0; op8 = '0; a16 = '0; b16 = '0; op16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(ov8), 32'd0);
        chk("rst.result", 32'(res8), 32'd0);
        chk("rst.busy", 32'(busy8), 32'd0);
        chk("rst.in_ready", 32'(ir8), 32'd0);
        chk("rst.out_valid16", 32'(ov16), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_rel.in_ready", 32'(ir8), 32'd1);

        // ADD, then backpressure and a back-to-back XOR issued from DONE
        sb.push_back(mk("add8", 32'h2C, 1'b1, 1'b0, 1'b0, 1));
        issue(1'b0, OP_ADD, 16'd200, 16'd100);
        wait_valid(1'b0, lat);
        collect(1'b0, lat, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.res", 32'(res8), 32'h2C);
            chk("hold.carry", 32'(c8), 32'd1);
            chk("hold.out_valid", 32'(ov8), 32'd1);
            chk("hold.in_ready", 32'(ir8), 32'd0);
        end
        @(negedge clk);
        or8 = 1'b1; iv8 = 1'b1; a8 = 8'hF0; b8 = 8'hFF; op8 = OP_XOR;
        sb.push_back(mk("xor8_b2b", 32'h0F, 1'b0, 1'b0, 1'b0, 1));
        #1 chk("b2b.in_ready", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b0;
        scramble();
        wait_valid(1'b0, lat);
        collect(1'b0, lat, 1'b1);

`ifdef ALU_ITER_MULDIV_EN
        sb.push_back(mk("mul20x13", 32'h04, 1'b1, 1'b0, 1'b0, 9));
        sb.push_back(mk("mul12x10", 32'h78, 1'b0, 1'b0, 1'b0, 9));
        sb.push_back(mk("div100/7", 32'd14, 1'b0, 1'b0, 1'b0, 9));
        sb.push_back(mk("div5/0",   32'hFF, 1'b0, 1'b0, 1'b1, 1));
`else
        sb.push_back(mk("mul20x13", 32'h0, 1'b0, 1'b1, 1'b0, 1));
        sb.push_back(mk("mul12x10", 32'h0, 1'b0, 1'b1, 1'b0, 1));
        sb.push_back(mk("div100/7", 32'h0, 1'b0, 1'b1, 1'b0, 1));
        sb.push_back(mk("div5/0",   32'h0, 1'b0, 1'b1, 1'b0, 1));
`endif
        issue(1'b0, OP_MUL, 16'd20, 16'd13);
        chk("mul.busy", 32'(busy8), 32'd1);
        wait_valid(1'b0, lat);
        collect(1'b0, lat, 1'b1);
        run(1'b0, OP_MUL, 16'd12, 16'd10);
        run(1'b0, OP_DIV, 16'd100, 16'd7);
        run(1'b0, OP_DIV, 16'd5, 16'd0);

        // every opcode with random operands, then edge operands
        for (int op = 0; op < 16; op++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            sb.push_back(model($sformatf("op%0d_8", op), 8, 4'(op), ra, rb));
            run(1'b0, 4'(op), ra, rb);
        end
        sb.push_back(model("add_ff_01", 8, OP_ADD, 64'hFF, 64'h01));  run(1'b0, OP_ADD, 16'hFF, 16'h01);
        sb.push_back(model("sub_00_01", 8, OP_SUB, 64'h00, 64'h01));  run(1'b0, OP_SUB, 16'h00, 16'h01);
        sb.push_back(model("shl_80", 8, OP_SHL1, 64'h80, 64'h00));    run(1'b0, OP_SHL1, 16'h80, 16'h00);
        sb.push_back(model("ror_01", 8, OP_ROR1, 64'h01, 64'h00));    run(1'b0, OP_ROR1, 16'h01, 16'h00);
        sb.push_back(model("div_ff_ff", 8, OP_DIV, 64'hFF, 64'hFF));  run(1'b0, OP_DIV, 16'hFF, 16'hFF);
        sb.push_back(model("mul_ff_ff", 8, OP_MUL, 64'hFF, 64'hFF));  run(1'b0, OP_MUL, 16'hFF, 16'hFF);

        // WIDTH=16
        sb.push_back(mk("sub16_1_2", 32'hFFFF, 1'b1, 1'b0, 1'b0, 1));   run(1'b1, OP_SUB, 16'h0001, 16'h0002);
        sb.push_back(mk("rol16_8001", 32'h0003, 1'b0, 1'b0, 1'b0, 1));  run(1'b1, OP_ROL1, 16'h8001, 16'h0000);
        sb.push_back(mk("sub16_eq", 32'h0000, 1'b0, 1'b1, 1'b0, 1));    run(1'b1, OP_SUB, 16'h1234, 16'h1234);
        sb.push_back(model("mul16", 16, OP_MUL, 64'h1234, 64'h0100));   run(1'b1, OP_MUL, 16'h1234, 16'h0100);
        sb.push_back(model("div16", 16, OP_DIV, 64'hFFFF, 64'h0003));   run(1'b1, OP_DIV, 16'hFFFF, 16'h0003);

        // reset on the 4th cycle of a DIV
        issue(1'b0, OP_DIV, 16'd100, 16'd7);
`ifdef ALU_ITER_MULDIV_EN
        for (int i = 0; i < 3; i++) begin
            chk("div_pre_rst.out_valid", 32'(ov8), 32'd0);
            @(posedge clk); #1;
        end
`endif
        @(negedge clk); rst = 1'b1; #1;
        chk("mid_rst.in_ready", 32'(ir8), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst.out_valid", 32'(ov8), 32'd0);
        chk("mid_rst.result", 32'(res8), 32'd0);
        chk("mid_rst.carry", 32'(c8), 32'd0);
        chk("mid_rst.zero", 32'(z8), 32'd0);
        chk("mid_rst.dbz", 32'(d8), 32'd0);
        chk("mid_rst.busy", 32'(busy8), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst.in_ready", 32'(ir8), 32'd1);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            chk("post_rst.no_valid", 32'(ov8), 32'd0);
        end
        sb.push_back(mk("add_after_rst", 32'h03, 1'b0, 1'b0, 1'b0, 1));
        run(1'b0, OP_ADD, 16'd1, 16'd2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
